// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   MULT/MULTU use a radix-2 shift-add multiplier on operand magnitudes.
//   DIV/DIVU use radix-2 restoring division on magnitudes. Every iterative
//   operation takes WIDTH busy cycles. MTHI/MTLO load HI/LO in one edge.
//
//   Optional feature (macro MULDIV_DIVZERO_EN): adds the divzero output.
//   A divide by zero then finishes after one busy cycle with HI/LO untouched.
//   Without the macro, a divide by zero runs the normal WIDTH-cycle algorithm.
//
// Parameters
//   WIDTH    operand/result width in bits (even, >= 8)
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   start    request strobe. It is accepted only while busy is low.
//   op       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            11x no-op
//   a, b     operands. a also carries the MTHI/MTLO data.
//   busy     iterative operation in progress
//   done     one-cycle pulse when HI/LO are written by a MULT/DIV
//   hi, lo   HI and LO registers
//   divzero  divide-by-zero flag (MULDIV_DIVZERO_EN only)
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_EN
   ,
   output logic             divzero
`endif
);

   localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);

   localparam logic [0:0]      S_IDLE = 1'b0;
   localparam logic [0:0]      S_RUN  = 1'b1;

   localparam logic [2:0]      OP_MTHI = 3'b100;
   localparam logic [2:0]      OP_MTLO = 3'b101;

   logic [0:0]       state;
   logic [CW-1:0]    count;

   // Operation context captured at acceptance
   logic             is_div_q;
   logic             neg_lo_q;     // negate product / quotient
   logic             neg_hi_q;     // negate remainder
   logic [WIDTH-1:0] opnd_q;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi_q;     // partial product high / remainder
   logic [WIDTH-1:0] acc_lo_q;     // multiplier -> product low / dividend -> quotient
`ifdef MULDIV_DIVZERO_EN
   logic             dz_q;
`endif

   logic             accept;
   logic             arith;
   logic             sgn_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     trial;
   logic               ge;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   nxt_hi;
   logic [WIDTH-1:0]   nxt_lo;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign busy   = (state == S_RUN);
   assign accept = start & ~busy;
   assign arith  = ~op[2];
   assign sgn_op = ~op[0];                 // MULT and DIV are the signed forms
   assign a_neg  = sgn_op & a[WIDTH-1];
   assign b_neg  = sgn_op & b[WIDTH-1];
   assign a_mag  = a_neg ? -a : a;         // the most-negative value maps to 2^(WIDTH-1) unsigned
   assign b_mag  = b_neg ? -b : b;

   // One iteration of either algorithm, plus the final sign fixup
   // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      addend  = acc_lo_q[0] ? opnd_q : '0;
      sum     = {1'b0, acc_hi_q} + {1'b0, addend};

      // The remainder stays below the divisor, so the low WIDTH bits of the difference are exact when ge=1.
      trial   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      ge      = (trial >= {1'b0, opnd_q});
      diff    = trial[WIDTH-1:0] - opnd_q;

      if (is_div_q) begin
         nxt_hi = ge ? diff : trial[WIDTH-1:0];
         nxt_lo = {acc_lo_q[WIDTH-2:0], ge};
      end else begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
      end

      product = {nxt_hi, nxt_lo};
      if (neg_lo_q) begin
         product = -product;
      end

      if (is_div_q) begin
         res_hi = neg_hi_q ? -nxt_hi : nxt_hi;
         res_lo = neg_lo_q ? -nxt_lo : nxt_lo;
      end else begin
         res_hi = product[2*WIDTH-1:WIDTH];
         res_lo = product[WIDTH-1:0];
      end
   end

   // Control and architectural state
   // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef MULDIV_DIVZERO_EN
         divzero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (arith) begin
                     state   <= S_RUN;
                     count   <= '0;
`ifdef MULDIV_DIVZERO_EN
                     divzero <= 1'b0;
`endif
                  end else if (op == OP_MTHI) begin
                     hi <= a;
                  end else if (op == OP_MTLO) begin
                     lo <= a;
                  end
               end
            end
            default: begin
`ifdef MULDIV_DIVZERO_EN
               if (dz_q) begin
                  state   <= S_IDLE;
                  done    <= 1'b1;
                  divzero <= 1'b1;
               end else
`endif
               if (count == LAST) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                  hi    <= res_hi;
                  lo    <= res_lo;
               end else begin
                  count <= count + CW'(1);
               end
            end
         endcase
      end
   end

   // Datapath. Its contents only matter between acceptance and done.
   // NOTE: datapath registers carry no reset; they are always loaded on acceptance before being used.
   always_ff @(posedge clk) begin
      if (accept && arith) begin
         is_div_q <= op[1];
         acc_hi_q <= '0;
         if (op[1]) begin
            opnd_q   <= b_mag;
            acc_lo_q <= a_mag;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
         end else begin
            opnd_q   <= a_mag;
            acc_lo_q <= b_mag;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= 1'b0;
         end
`ifdef MULDIV_DIVZERO_EN
         dz_q <= op[1] & (b == '0);
`endif
      end else if (state == S_RUN) begin
         acc_hi_q <= nxt_hi;
         acc_lo_q <= nxt_lo;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (WIDTH=32). Each expected HI/LO
//   result and busy length is pushed to a scoreboard when a request is driven.
//   The entry is popped and compared when done pulses. The bench builds both
//   with and without MULDIV_DIVZERO_EN.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int         W        = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
   logic         divzero;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cycles;
      logic         dz;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] mhi;     // model of HI
   logic [W-1:0] mlo;     // model of LO

   muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
`ifdef MULDIV_DIVZERO_EN
      ,
      .divzero (divzero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t              e;
      longint            sx;
      longint            sy;
      longint            sq;
      longint            sr;
      longint unsigned   ux;
      longint unsigned   uy;
      logic [63:0]       p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      e.cycles = W;
      e.dz     = 1'b0;
      e.hi     = '0;
      e.lo     = '0;
      if (o[1] && y == '0) begin
`ifdef MULDIV_DIVZERO_EN
         e.hi     = mhi;
         e.lo     = mlo;
         e.cycles = 1;
         e.dz     = 1'b1;
`else
         e.hi = x;                                        // remainder keeps the dividend
         e.lo = (o == OP_DIV && x[W-1]) ? 32'h1 : '1;     // all-ones magnitude, negated if dividend < 0
`endif
      end else begin
         case (o)
            OP_MULT: begin
               p = sx * sy;
               e.hi = p[63:32];
               e.lo = p[31:0];
            end
            OP_MULTU: begin
               p = ux * uy;
               e.hi = p[63:32];
               e.lo = p[31:0];
            end
            OP_DIV: begin
               sq = sx / sy;
               sr = sx % sy;
               p = sq;
               e.lo = p[31:0];
               p = sr;
               e.hi = p[31:0];
            end
            default: begin
               p = ux / uy;
               e.lo = p[31:0];
               p = ux % uy;
               e.hi = p[31:0];
            end
         endcase
      end
      return e;
   endfunction

   // Drive one request for one edge. Returns 1 time unit after the acceptance edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit use_model, input logic [W-1:0] hc, input logic [W-1:0] lc);
      exp_t e;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (!o[2]) begin
         if (use_model) begin
            e = model(o, x, y);
         end else begin
            e.hi = hc;
            e.lo = lc;
            e.cycles = W;
            e.dz = 1'b0;
         end
         sb.push_back(e);
      end else if (o == OP_MTHI) begin
         mhi = x;
      end else if (o == OP_MTLO) begin
         mlo = x;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!o[2]) begin
         check("accept_busy", busy, 1'b1);
         check("accept_done_low", done, 1'b0);
`ifdef MULDIV_DIVZERO_EN
         check("accept_divzero_clr", divzero, 1'b0);
`endif
      end else begin
         check("mt_busy", busy, 1'b0);
         check("mt_done", done, 1'b0);
      end
   endtask

   // Wait for done (bounded), then pop and compare the scoreboard entry.
   task automatic wait_done(input string tag, input bit mess);
      int           n      = 0;
      bit           stable = 1'b1;
      logic [W-1:0] h0     = mhi;
      logic [W-1:0] l0     = mlo;
      exp_t         e;
      for (int i = 0; i < 200 && done !== 1'b1; i++) begin
         if (busy === 1'b1) n++;
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         if (mess) begin
            start = 1'b1;
            op    = 3'($urandom_range(0, 5));
            a     = $urandom;
            b     = $urandom;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_in_done"}, busy, 1'b0);
      check({tag, "_hilo_stable"}, stable, 1'b1);
      check({tag, "_sb_has_entry"}, (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_busy_cycles"}, n, e.cycles);
         check({tag, "_hi"}, hi, e.hi);
         check({tag, "_lo"}, lo, e.lo);
`ifdef MULDIV_DIVZERO_EN
         check({tag, "_divzero"}, divzero, e.dz);
`endif
         mhi = e.hi;
         mlo = e.lo;
      end
   endtask

   initial begin
      bit saw_done;
      logic [2:0]   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;

      reset = 1'b1;
      start = 1'b0;
      op    = OP_NOP;
      a     = '0;
      b     = '0;
      mhi   = '0;
      mlo   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
`ifdef MULDIV_DIVZERO_EN
      check("rst_divzero", divzero, 1'b0);
`endif
      reset = 1'b0;

      // Signed multiply, issued on the first edge after reset release
      issue(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
      wait_done("mult_neg", 1'b0);

      // Issued in the done cycle; start while busy and changing inputs must not disturb it
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
      wait_done("multu_max", 1'b1);

      issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
      wait_done("div_neg", 1'b0);

      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);
      wait_done("div_ovf", 1'b0);

      // MTHI then MTLO on consecutive edges
      issue(OP_MTHI, 32'h12345678, '0, 1'b0, '0, '0);
      issue(OP_MTLO, 32'h9ABCDEF0, '0, 1'b0, '0, '0);
      check("mt_hi", hi, 32'h12345678);
      check("mt_lo", lo, 32'h9ABCDEF0);

      // The no-op must leave HI/LO alone
      issue(OP_NOP, 32'hDEADBEEF, 32'h1, 1'b0, '0, '0);
      check("nop_hi", hi, mhi);
      check("nop_lo", lo, mlo);

      // Divide by zero
      issue(OP_DIVU, 32'h00000007, 32'h00000000, 1'b1, '0, '0);
      wait_done("divu_zero", 1'b0);
`ifdef MULDIV_DIVZERO_EN
      @(posedge clk);
      #1;
      check("divzero_held", divzero, 1'b1);
`else
      check("divu_zero_hi_const", hi, 32'h00000007);
      check("divu_zero_lo_const", lo, 32'hFFFFFFFF);
`endif

      // Mixed random operations against the reference model
      for (int k = 0; k < 8; k++) begin
         ro = 3'($urandom_range(0, 3));
         rx = $urandom;
         ry = (k % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
         if (k == 5) ry = 32'hFFFFFFFF;
         issue(ro, rx, ry, 1'b1, '0, '0);
         wait_done($sformatf("rand%0d", k), 1'b0);
      end

      // Reset asserted at busy cycle 10 of a MULTU aborts it
      issue(OP_MULTU, 32'h0000_1234, 32'h0000_5678, 1'b1, '0, '0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("abort_busy_before", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_hi", hi, '0);
      check("abort_lo", lo, '0);
      void'(sb.pop_back());
      mhi = '0;
      mlo = '0;
      saw_done = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 1'b0);
      reset = 1'b0;

      // MULT issued right after reset release
      issue(OP_MULT, 32'h7FFFFFFF, 32'h80000000, 1'b1, '0, '0);
      wait_done("post_reset_mult", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled on rising clk.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 SHALL have port a  input  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
REQ-007 SHALL have port b  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have port busy  output  1  iterative operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; HI/LO just updated by MULT/DIV.
REQ-010 SHALL have port hi  output  WIDTH  HI register.
REQ-011 SHALL have port lo  output  WIDTH  LO register.
REQ-012 SHALL have port divzero  output  1  divide-by-zero flag (present only per REQ-031).

Function
REQ-013 SHALL accept a request on a rising edge where start=1 and busy=0; requests with busy=1 are ignored, with no queuing.
REQ-014 SHALL, on an accepted MTHI/MTLO, load a into hi/lo at that edge, leave the other register unchanged, and assert neither busy nor done.
REQ-015 SHALL, on an accepted op 11x, change no state.
REQ-016 SHALL implement a two-state FSM: IDLE -> RUN on an accepted MULT/MULTU/DIV/DIVU; RUN -> IDLE after exactly WIDTH iteration cycles.
REQ-017 SHALL hold busy=1 for exactly WIDTH cycles, starting the cycle after acceptance.
REQ-018 SHALL, on the edge that ends RUN, write hi/lo and assert done=1 for exactly one cycle, with busy=0 in that cycle.
REQ-019 SHALL allow a new request in the done cycle; the issue-to-issue throughput is WIDTH+1 cycles.
REQ-020 SHALL capture a, b and op at acceptance; input changes during RUN have no effect.
REQ-021 SHALL produce, for MULT/MULTU, the 2*WIDTH-bit product (signed/unsigned) with the upper half in hi and the lower half in lo.
REQ-022 SHALL compute DIV/DIVU with radix-2 restoring division on magnitudes, placing the quotient in lo and the remainder in hi.
REQ-023 SHALL, for DIV, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-024 SHALL, for DIV of the most-negative value by -1, produce lo = most-negative value and hi = 0 (wrap, no flag).
REQ-025 SHALL keep hi/lo stable during RUN; MTHI/MTLO issued while busy are ignored per REQ-013.

Reset
REQ-026 SHALL, while reset=1, asynchronously force the FSM to IDLE and set busy=0, done=0, hi=0, lo=0, divzero=0.
REQ-027 SHALL, on reset during RUN, abort the operation with no done pulse and no hi/lo update.
REQ-028 SHALL accept a request on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL use the macro MULDIV_DIVZERO_EN.
REQ-030 SHALL, without MULDIV_DIVZERO_EN, run DIV/DIVU with b=0 for the full WIDTH cycles, giving lo = all ones and hi = a (DIVU); for DIV, apply the REQ-023 sign fixups to the magnitude results.
REQ-031 SHALL, with MULDIV_DIVZERO_EN, provide the divzero port, complete DIV/DIVU with b=0 in one busy cycle, leave hi/lo unchanged, pulse done, and hold divzero=1 until the next accepted MULT/MULTU/DIV/DIVU.

Verification
REQ-032 SHALL cover (WIDTH=32) MULT a=FFFFFFFD, b=00000005 -> busy for 32 cycles, then done with hi=FFFFFFFF, lo=FFFFFFF1.
REQ-033 SHALL cover MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; also check that start while busy, and changing a/b during RUN, do not alter the result.
REQ-034 SHALL cover DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; and DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-035 SHALL cover MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles -> hi=12345678, lo=9ABCDEF0, with busy and done never asserted.
REQ-036 SHALL cover DIVU a=00000007, b=0 -> with the macro: 1 busy cycle, done, divzero=1, hi/lo unchanged; without it: after 32 cycles, lo=FFFFFFFF, hi=00000007.
REQ-037 SHALL cover reset asserted at busy cycle 10 of a MULTU -> immediately busy=0, hi=lo=0, no done pulse; then a MULT issued right after reset completes correctly.
